// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan serializer.
package mux_scan_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam int K_DEF  = 32;
  localparam int CW_DEF = 16;

endpackage

// File: rtl/mux_scan_serializer_if.sv
// Load-word and serial-bit valid/ready handshakes of the scan serializer.
interface mux_scan_serializer_if
  import mux_scan_pkg::*;
#(
  parameter int K = K_DEF
);

  logic         load_valid;
  logic         load_ready;
  logic [K-1:0] load_data;
  logic         bit_valid;
  logic         bit_ready;
  logic         bit_out;
  logic         last;

  modport master (
    output load_valid,
    output load_data,
    output bit_ready,
    input  load_ready,
    input  bit_valid,
    input  bit_out,
    input  last
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  bit_ready,
    output load_ready,
    output bit_valid,
    output bit_out,
    output last
  );

endinterface

// File: rtl/mux_scan_serializer_mux_32x1.sv
// Bit-select mux; width is N, select is SW bits.
module mux_32x1 #(
  parameter int N  = 32,
  parameter int SW = 5
) (
  input  logic [N-1:0]  d,
  input  logic [SW-1:0] s,
  output logic          y
);

  assign y = d[s];

endmodule

// File: rtl/mux_scan_serializer.sv
// Scans a loaded word bit-by-bit onto a serial handshake, driving sel.
// MUX_SCAN_MSB_FIRST_EN: scan from bit K-1 down to 0 instead of 0 up.
module mux_scan_serializer
  import mux_scan_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int SW = $clog2(K),
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_scan_serializer_if.slave io,
  output logic [SW-1:0] sel,
  output logic          busy,
  output logic [CW-1:0] frame_cnt
);

`ifdef MUX_SCAN_MSB_FIRST_EN
  localparam logic [SW-1:0] SEL_START = SW'(K-1);
  localparam logic [SW-1:0] SEL_END   = '0;
`else
  localparam logic [SW-1:0] SEL_START = '0;
  localparam logic [SW-1:0] SEL_END   = SW'(K-1);
`endif

  state_t       state;
  logic [K-1:0] data_q;
  logic [SW-1:0] sel_nxt;

`ifdef MUX_SCAN_MSB_FIRST_EN
  assign sel_nxt = sel - 1'b1;
`else
  assign sel_nxt = sel + 1'b1;
`endif

  assign busy          = (state == SHIFT);
  assign io.bit_valid  = busy;
  assign io.last       = busy && (sel == SEL_END);
  // Ready during the last-bit handshake so a new word loads bubble-free
  assign io.load_ready = !busy || (io.last && io.bit_ready);

  mux_32x1 #(
    .N  (K),
    .SW (SW)
  ) u_mux (
    .d (data_q),
    .s (sel),
    .y (io.bit_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= SEL_START;
      data_q    <= '0;
      frame_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.load_valid) begin
            data_q <= io.load_data;
            sel    <= SEL_START;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (io.bit_ready) begin
            if (io.last) begin
              frame_cnt <= frame_cnt + 1'b1;
              if (io.load_valid) begin
                data_q <= io.load_data;
                sel    <= SEL_START;
              end else begin
                state <= IDLE;
              end
            end else begin
              sel <= sel_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
